// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite blitter: FSM state encoding,
// the transparent palette index and the buffered pixel record.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } blit_state_t;

    localparam logic [3:0]  TRANSPARENT  = 4'h0;
    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned PIX_AW       = 19;

    typedef struct packed {
        logic [PIX_AW-1:0] fb_addr;
        logic [3:0]        data;
    } pix_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry registered FIFO of pixel records; slot0 is always the head,
// so the head stays stable while the consumer stalls.
module pix_skid_fifo
    import sprite_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       push,
    input  pix_t       push_pix,
    input  logic       pop,
    output pix_t       head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    pix_t       slot0_q, slot0_d;
    pix_t       slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        do_pop  = pop && (count_q != 2'd0);
        unique case ({push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = push_pix;
                else                 slot1_d = push_pix;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = push_pix;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_pix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head  = slot0_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/sprite_blitter.sv
// Walks a 1-cycle-latency sprite ROM and copies opaque, on-screen pixels
// into the frame buffer at the latched origin, honouring fb_ready.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W    = 23,
    parameter int unsigned SPR_H    = 22,
    parameter int unsigned ROM_AW   = 9,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF,
    parameter int unsigned FB_AW    = 19
)(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        org_x,
    input  logic [9:0]        org_y,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [3:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    blit_state_t       state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [9:0]        org_x_q, org_x_d;
    logic [9:0]        org_y_q, org_y_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [10:0]       tag_x_q, tag_x_d;
    logic [10:0]       tag_y_q, tag_y_d;
    logic              tag_vld_q, tag_vld_d;

    pix_t              push_pix, head_pix;
    logic              push, pop, fifo_full, fifo_empty;
    logic [1:0]        fifo_count;
    logic              keep, last_pos;
    logic [2:0]        occ_after, cnt_next;

    // Capture stage: the tag issued last cycle lines up with rom_data now.
    always_comb begin
        keep = tag_vld_q
            && (rom_data != TRANSPARENT)
            && (32'(tag_x_q) < SCREEN_W)
            && (32'(tag_y_q) < SCREEN_H);
        push             = keep && !fifo_full;
        push_pix.fb_addr = PIX_AW'(32'(tag_y_q) * SCREEN_W + 32'(tag_x_q));
        push_pix.data    = rom_data;
        pop              = !fifo_empty && fb_ready;
        // Occupancy is taken after this cycle's pop so a free-flowing
        // frame buffer sustains one issue per cycle.
        occ_after = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, tag_vld_q};
        cnt_next  = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, push};
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        rom_addr_d = rom_addr_q;
        tag_x_d    = 11'(org_x_q) + 11'(col_q);
        tag_y_d    = 11'(org_y_q) + 11'(row_q);
        tag_vld_d  = 1'b0;
        last_pos   = (col_q == CW'(SPR_W - 1)) && (row_q == RW'(SPR_H - 1));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    org_x_d    = org_x;
                    org_y_d    = org_y;
                    col_d      = '0;
                    row_d      = '0;
                    rom_addr_d = '0;
                end
            end
            RUN: begin
                if (occ_after < 3'd2) begin
                    tag_vld_d = 1'b1;
                    if (last_pos) begin
                        state_d = DRAIN;
                    end else begin
                        rom_addr_d = rom_addr_q + ROM_AW'(1);
                        if (col_q == CW'(SPR_W - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_next == 3'd0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            org_x_q    <= '0;
            org_y_q    <= '0;
            rom_addr_q <= '0;
            tag_x_q    <= '0;
            tag_y_q    <= '0;
            tag_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            rom_addr_q <= rom_addr_d;
            tag_x_q    <= tag_x_d;
            tag_y_q    <= tag_y_d;
            tag_vld_q  <= tag_vld_d;
        end
    end

    pix_skid_fifo u_fifo (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .push     (push),
        .push_pix (push_pix),
        .pop      (pop),
        .head     (head_pix),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign rom_addr = rom_addr_q;
    assign fb_we    = !fifo_empty;
    assign fb_addr  = FB_AW'(head_pix.fb_addr);
    assign fb_data  = head_pix.data;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: table of draws with hand-computed
// totals plus a scoreboard of every frame-buffer write.
module tb_sprite_blitter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  org_x = '0;
    logic [9:0]  org_y = '0;
    logic [8:0]  rom_addr;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        done;

    always #5 Clk = ~Clk;

    sprite_blitter #(
        .SPR_W    (23),
        .SPR_H    (22),
        .ROM_AW   (9),
        .SCREEN_W (640),
        .SCREEN_H (480),
        .FB_AW    (19)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .org_x    (org_x),
        .org_y    (org_y),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int ox, oy, mode, rmode, repulse, start_in_done, timing;
        int n_wr, first_a, last_a;
    } vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    vec_t vecs[5];
    wr_t  expq[$];
    int   nerr = 0, nchk = 0;
    int   cyc = 0, t0 = 0;
    int   rom_mode = 0, rdy_mode = 0;
    bit   mon_en = 1'b0;
    int   wr_cnt, done_cnt, first_addr, last_addr, first_cyc, last_cyc, done_cyc;
    bit   prev_stall = 1'b0;
    int   prev_addr, prev_data;

    function automatic logic [3:0] rom_val(input int a, input int mode);
        case (mode)
            0:       return 4'h5;
            1:       return (a % 2 == 0) ? 4'h0 : 4'h7;
            default: return 4'((a % 15) + 1);
        endcase
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) rom_data <= rom_val(int'(rom_addr), rom_mode);

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            fb_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_we", fb_we, 1);
                check("stall_hold_addr", fb_addr, prev_addr);
                check("stall_hold_data", fb_data, prev_data);
            end
            if (fb_we && fb_ready) begin
                nchk++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", fb_addr);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    if (fb_addr !== 19'(e.addr) || fb_data !== 4'(e.data)) begin
                        nerr++;
                        $display("FAIL write_%0d: got addr %0d data %0d expected addr %0d data %0d",
                                 wr_cnt, fb_addr, fb_data, e.addr, e.data);
                    end
                end
                if (wr_cnt == 0) begin
                    first_addr = int'(fb_addr);
                    first_cyc  = cyc - t0;
                end
                last_addr = int'(fb_addr);
                last_cyc  = cyc - t0;
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
            prev_stall = fb_we && !fb_ready;
            prev_addr  = int'(fb_addr);
            prev_data  = int'(fb_data);
        end
    end

    task automatic build_exp(input int ox, input int oy, input int mode);
        expq.delete();
        for (int r = 0; r < 22; r++) begin
            for (int c = 0; c < 23; c++) begin
                int a, d, x, y;
                a = r * 23 + c;
                d = int'(rom_val(a, mode));
                x = ox + c;
                y = oy + r;
                if (d != 0 && x < 640 && y < 480) expq.push_back('{y * 640 + x, d});
            end
        end
        wr_cnt = 0; done_cnt = 0;
        first_addr = -1; last_addr = -1;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
    endtask

    task automatic run_vec(input vec_t v);
        bit got_done;
        build_exp(v.ox, v.oy, v.mode);
        rom_mode = v.mode;
        rdy_mode = v.rmode;
        @(posedge Clk);
        #1;
        org_x  = 10'(v.ox);
        org_y  = 10'(v.oy);
        start  = 1'b1;
        t0     = cyc;
        mon_en = 1'b1;
        got_done = 1'b0;
        for (int k = 1; k <= 6000 && !got_done; k++) begin
            @(posedge Clk);
            #1;
            start = (v.repulse != 0) && (k == 40);
            if ((v.repulse != 0) && (k == 40)) begin
                org_x = 10'd300;
                org_y = 10'd300;
            end
            if (done) begin
                got_done = 1'b1;
                check("busy_low_in_done_cycle", busy, 0);
                if (v.start_in_done != 0) start = 1'b1;
            end
        end
        check("done_seen", got_done, 1);
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge Clk);
        #1;
        check("idle_busy_after_done", busy, 0);
        check("idle_we_after_done", fb_we, 0);
        mon_en   = 1'b0;
        rdy_mode = 0;
        check("write_count", wr_cnt, v.n_wr);
        check("first_fb_addr", first_addr, v.first_a);
        check("last_fb_addr", last_addr, v.last_a);
        check("done_pulses", done_cnt, 1);
        check("writes_missing", expq.size(), 0);
        if (v.timing != 0) begin
            check("first_write_cycle", first_cyc, 3);
            check("last_write_cycle", last_cyc, 508);
            check("done_cycle", done_cyc, 509);
        end
    endtask

    initial begin
        //          ox   oy  mode rdy rep sid tim  n_wr  first   last
        vecs[0] = '{100,  50, 0,  0,  0,  1,  1,  506,  32100,  45562};
        vecs[1] = '{100,  50, 1,  0,  0,  0,  0,  253,  32101,  45562};
        vecs[2] = '{630, 470, 0,  0,  0,  0,  0,  100, 301430, 307199};
        vecs[3] = '{  0,   0, 2,  1,  1,  0,  0,  506,      0,  13462};
        vecs[4] = '{620,   0, 0,  0,  0,  0,  0,  440,    620,  14079};

        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_we", fb_we, 0);
        check("reset_rom_addr", rom_addr, 0);
        Reset_n = 1'b1;

        run_vec(vecs[0]);

        // Idle reset after a draw has left rom_addr and the FIFO slots non-zero.
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("idle_reset_busy", busy, 0);
        check("idle_reset_done", done, 0);
        check("idle_reset_we", fb_we, 0);
        check("idle_reset_rom_addr", rom_addr, 0);
        check("idle_reset_fb_addr", fb_addr, 0);
        check("idle_reset_fb_data", fb_data, 0);
        Reset_n = 1'b1;

        for (int i = 1; i < 5; i++) run_vec(vecs[i]);

        // Abort a draw with reset after its 200th write, then redraw in full.
        build_exp(100, 50, 0);
        rom_mode = 0;
        rdy_mode = 0;
        @(posedge Clk);
        #1;
        org_x  = 10'd100;
        org_y  = 10'd50;
        start  = 1'b1;
        t0     = cyc;
        mon_en = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 1000 && wr_cnt < 200; k++) begin
            @(posedge Clk);
            #1;
        end
        check("abort_reached_200", wr_cnt, 200);
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        check("abort_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
